// File: rtl/lift_req_queue.sv
// Hall-call request queue feeding the lift FSM (qEmpty/din).
// Ports: clk, rst_n, btn[5:0], done -> req_code[2:0], q_empty, lamp[5:0], count.
module lift_req_queue #(
  parameter int DEPTH = 8,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [5:0]    btn,
  input  logic          done,
  output logic [2:0]    req_code,
  output logic          q_empty,
  output logic [5:0]    lamp,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [5:0]    waiting, waiting_nx;
  logic [5:0]    queued, queued_nx;
  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;

  logic       enq, pop;
  logic [2:0] sel;
  logic [2:0] head_idx;

  function automatic logic [2:0] code_of(input logic [2:0] i);
    logic [2:0] c;
    c = 3'b000;
    unique case (i)
      3'd0: c = 3'b001;
      3'd1: c = 3'b010;
      3'd2: c = 3'b011;
      3'd3: c = 3'b110;
      3'd4: c = 3'b111;
      3'd5: c = 3'b100;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] idx_of(input logic [2:0] c);
    logic [2:0] i;
    i = 3'd0;
    unique case (c)
      3'b001: i = 3'd0;
      3'b010: i = 3'd1;
      3'b011: i = 3'd2;
      3'b110: i = 3'd3;
      3'b111: i = 3'd4;
      3'b100: i = 3'd5;
      default: i = 3'd0;
    endcase
    return i;
  endfunction

  assign enq      = |waiting;
  assign pop      = done && (count != '0);
  assign head_idx = idx_of(mem[rd_ptr]);

  // Lowest pending index wins the single enqueue slot.
  always_comb begin
    sel = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (waiting[i]) sel = 3'(i);
    end
  end

  always_comb begin
    queued_nx  = queued;
    waiting_nx = waiting;
    if (pop) queued_nx[head_idx] = 1'b0;
    if (enq) begin
      queued_nx[sel]  = 1'b1;
      waiting_nx[sel] = 1'b0;
    end
    // A press on the head being popped counts as a fresh request.
    for (int i = 0; i < 6; i++) begin
      if (btn[i] && !waiting[i] &&
          (!queued[i] || (pop && head_idx == 3'(i))))
        waiting_nx[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waiting <= '0;
      queued  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 3'b000;
    end else begin
      waiting <= waiting_nx;
      queued  <= queued_nx;
      if (enq) begin
        mem[wr_ptr] <= code_of(sel);
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (enq && !pop)
        count <= count + CW'(1);
      else if (pop && !enq)
        count <= count - CW'(1);
    end
  end

  assign req_code = (count != '0) ? mem[rd_ptr] : 3'b000;
  assign q_empty  = (count == '0);
  assign lamp     = waiting | queued;

endmodule

// File: tb/tb_lift_req_queue.sv
// Directed bench for lift_req_queue, run on DEPTH=8 and DEPTH=6 copies
// sharing the same stimulus.
module tb_lift_req_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] btn;
  logic       done;

  logic [2:0] rc8, rc6;
  logic       qe8, qe6;
  logic [5:0] lp8, lp6;
  logic [3:0] ct8;
  logic [2:0] ct6;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lift_req_queue #(.DEPTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .btn(btn), .done(done),
    .req_code(rc8), .q_empty(qe8), .lamp(lp8), .count(ct8)
  );

  lift_req_queue #(.DEPTH(6)) u6 (
    .clk(clk), .rst_n(rst_n), .btn(btn), .done(done),
    .req_code(rc6), .q_empty(qe6), .lamp(lp6), .count(ct6)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check both instances against the same expectation.
  task automatic chk_all(input string tag, input int cnt,
                         input int code, input int lmp);
    chk({tag, "/cnt8"}, int'(ct8), cnt);
    chk({tag, "/cnt6"}, int'(ct6), cnt);
    chk({tag, "/code8"}, int'(rc8), code);
    chk({tag, "/code6"}, int'(rc6), code);
    chk({tag, "/qe8"}, int'(qe8), (cnt == 0) ? 1 : 0);
    chk({tag, "/qe6"}, int'(qe6), (cnt == 0) ? 1 : 0);
    chk({tag, "/lamp8"}, int'(lp8), lmp);
    chk({tag, "/lamp6"}, int'(lp6), lmp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] codes [6];
    codes[0] = 3'b001; codes[1] = 3'b010; codes[2] = 3'b011;
    codes[3] = 3'b110; codes[4] = 3'b111; codes[5] = 3'b100;

    rst_n = 1'b0;
    btn   = '0;
    done  = 1'b0;
    #1;
    chk_all("reset", 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single press of 3U.
    btn = 6'b000100;
    step();
    btn = '0;
    chk_all("t1_wait", 0, 0, 6'b000100);
    step();
    chk_all("t1_enq", 1, 3'b011, 6'b000100);
    done = 1'b1;
    step();
    done = 1'b0;
    chk_all("t1_pop", 0, 0, 0);

    // Same-cycle presses enqueue lowest index first.
    btn = 6'b101001;
    step();
    btn = '0;
    step();
    chk_all("t2_e1", 1, 3'b001, 6'b101001);
    step();
    chk_all("t2_e2", 2, 3'b001, 6'b101001);
    step();
    chk_all("t2_e3", 3, 3'b001, 6'b101001);
    done = 1'b1;
    step();
    chk_all("t2_p1", 2, 3'b110, 6'b101000);
    step();
    chk_all("t2_p2", 1, 3'b100, 6'b100000);
    step();
    chk_all("t2_p3", 0, 0, 0);
    done = 1'b0;

    // Duplicates of 2U are absorbed; re-press while popping is accepted.
    btn = 6'b000010;
    step();
    step();
    step();
    btn = '0;
    chk_all("t3_dup", 1, 3'b010, 6'b000010);
    btn  = 6'b000010;
    done = 1'b1;
    step();
    btn  = '0;
    done = 1'b0;
    chk_all("t3_repop", 0, 0, 6'b000010);
    step();
    chk_all("t3_reenq", 1, 3'b010, 6'b000010);
    done = 1'b1;
    step();
    done = 1'b0;
    chk_all("t3_clr", 0, 0, 0);

    // All buttons held: occupancy stops at six.
    btn = 6'b111111;
    for (int i = 0; i < 10; i++) step();
    btn = '0;
    chk_all("t4_full", 6, 3'b001, 6'b111111);
    done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t4_ord8_%0d", i), int'(rc8), int'(codes[i]));
      chk($sformatf("t4_ord6_%0d", i), int'(rc6), int'(codes[i]));
      step();
    end
    step();
    step();
    done = 1'b0;
    chk_all("t4_drain", 0, 0, 0);

    // Alternating 3U/3D to walk both pointer sets around.
    for (int i = 0; i < 20; i++) begin
      btn = (i % 2 == 0) ? 6'b000100 : 6'b010000;
      step();
      btn = '0;
      step();
      chk($sformatf("t5_c8_%0d", i), int'(rc8),
          (i % 2 == 0) ? 3 : 7);
      chk($sformatf("t5_c6_%0d", i), int'(rc6),
          (i % 2 == 0) ? 3 : 7);
      done = 1'b1;
      step();
      done = 1'b0;
      chk($sformatf("t5_n8_%0d", i), int'(ct8), 0);
      chk($sformatf("t5_n6_%0d", i), int'(ct6), 0);
    end

    // Enqueue of 3D on the same edge that pops 3U.
    btn = 6'b000100;
    step();
    btn = '0;
    step();
    chk_all("t6_pre", 1, 3'b011, 6'b000100);
    btn = 6'b010000;
    step();
    btn = '0;
    done = 1'b1;
    step();
    done = 1'b0;
    chk_all("t6_swap", 1, 3'b111, 6'b010000);
    done = 1'b1;
    step();
    done = 1'b0;
    chk_all("t6_end", 0, 0, 0);

    // Asynchronous reset with four entries queued.
    btn = 6'b001111;
    step();
    btn = '0;
    for (int i = 0; i < 4; i++) step();
    chk_all("t7_pre", 4, 3'b001, 6'b001111);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("t7_async", 0, 0, 0);
    #3;
    rst_n = 1'b1;
    step();
    chk_all("t7_after", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lift_req_queue.md
Name: lift_req_queue

Overview:
- Hall-call request queue that sits directly upstream of the lift FSM and feeds its `qEmpty` and `din[2:0]` inputs.
- Captures the six hall-button pulses into sticky pending bits and suppresses duplicate requests.
- Serialises pending requests, one per cycle, into a FIFO in fixed priority order.
- Presents the FIFO head to the FSM and pops the head on the FSM's `done` pulse.
- Drives the hall-call lamps: a lamp stays lit while its request is waiting or queued.

Parameters:
- DEPTH, 8, number of FIFO entries; must be >= 6. Wrap-around is explicit at DEPTH-1, so DEPTH need not be a power of two.
- CW, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn  input  6  hall-button pulses. bit0=1U, bit1=2U, bit2=3U, bit3=2D, bit4=3D, bit5=4D. Any width is accepted; a level held high acts as a repeated press.
- done  input  1  from the lift FSM: the current head request has been served.
- req_code  output  3  head request code, driven to the FSM `din`.
- q_empty  output  1  high when the FIFO holds no entry; driven to the FSM `qEmpty`.
- lamp  output  6  hall-call lamps, bit mapping as `btn`; lamp = waiting | queued.
- count  output  CW  number of FIFO entries.

Behaviour:
- Code map (index -> code):
  - 0->3'b001, 1->3'b010, 2->3'b011
  - 3->3'b110, 4->3'b111, 5->3'b100
- State registers:
  - waiting[5:0]: latched but not yet enqueued.
  - queued[5:0]: present in the FIFO.
  - mem[DEPTH], rd_ptr, wr_ptr, count.
- Reset (asynchronous, rst_n=0):
  - waiting=0, queued=0, rd_ptr=wr_ptr=0, count=0.
  - Outputs: q_empty=1, req_code=3'b000, lamp=0, count=0.
  - Reset asserted mid-operation discards all requests immediately.
- Capture, each edge:
  - waiting[i] is set if btn[i]=1 and request i is not already waiting and not queued.
  - If request i is the head being popped this same edge, the press is accepted as a new request.
- Enqueue, each edge, at most one:
  - Select the lowest index i with waiting[i]=1, as registered before this edge.
  - Write code(i) to mem[wr_ptr]; wr_ptr wraps DEPTH-1 -> 0.
  - Clear waiting[i]; set queued[i].
  - A press sampled at edge N is enqueued at edge N+1 at the earliest, and q_empty falls after edge N+1.
- Pop, on an edge with done=1 and count!=0:
  - Clear queued[idx(mem[rd_ptr])]; rd_ptr wraps DEPTH-1 -> 0.
  - done while count==0 is ignored, with no state change.
- Simultaneous enqueue and pop: both occur and count is unchanged.
- Overflow is impossible: dedup bounds occupancy at 6 <= DEPTH. No full flag.
- Output logic:
  - req_code = mem[rd_ptr] when count!=0, else 3'b000 (combinational from registers).
  - q_empty = (count==0).
  - Held requests are served FIFO-order. Among requests pressed in the same cycle, lower index is enqueued first.
- No deadlock: every waiting bit is enqueued within 6 cycles.

Test Plan:
- Reset, then pulse btn=6'b000100 for 1 cycle -> after 2 edges: q_empty=0, req_code=3'b011, count=1, lamp=6'b000100. Pulse done -> next edge: q_empty=1, lamp=0, req_code=3'b000.
- Same cycle btn=6'b101001 (1U, 2D, 4D) -> enqueued on 3 consecutive edges as 001, 110, 100, count reaching 3. Three done pulses pop them in that order; lamp bits clear one per pop.
- Duplicate: press 2U three times while it is pending or at the head -> count stays 1. Press 2U again in the same cycle it is popped -> re-enqueued, count returns to 1 two edges later.
- Hold btn=6'b111111 for 10 cycles with done=0 -> count saturates at 6, codes in index order 001, 010, 011, 110, 111, 100, no overflow. Then done held high for 8 cycles -> all 6 popped in order, extra done ignored, count=0.
- Wrap-around with DEPTH=8: 20 request/pop cycles alternating 3U and 3D -> pointers wrap and the order is preserved.
- Wrap-around with DEPTH=6 (non-power-of-two): same alternating 3U/3D sequence, plus a cycle with simultaneous enqueue and pop -> count unchanged in that cycle, order preserved.
- Assert rst_n=0 asynchronously mid-clock with count=4 -> q_empty=1, count=0, lamp=0 immediately, without waiting for a clock edge.
